// File: rtl/key_pkg.sv
// Shared definitions for the key click decoder: FSM state encodings,
// click-count codes and the default timing constants.
package key_pkg;

   // Decoder FSM states: waiting for a first press, or collecting a group
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   // Click-count codes carried on evt_clicks
   localparam logic [1:0] CLK_NONE   = 2'd0;
   localparam logic [1:0] CLK_SINGLE = 2'd1;
   localparam logic [1:0] CLK_DOUBLE = 2'd2;
   localparam logic [1:0] CLK_TRIPLE = 2'd3;

   // Window timer width and default inter-click window (300 ms at 50 MHz),
   // written in the same style as the debounce stage's MAX constant
   localparam int          KEY_CNT_W  = 24;
   localparam logic [23:0] KEY_WINDOW = 24'd15_000_000;

endpackage

// File: rtl/click_window_timer.sv
// Inter-click window timer. Counts enabled cycles since the last clear and
// flags the cycle in which the count reaches WINDOW-1.
module click_window_timer
   import key_pkg::*;
#(
   parameter int               CNT_W  = KEY_CNT_W,
   parameter logic [CNT_W-1:0] WINDOW = KEY_WINDOW
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = WINDOW - CNT_W'(1);

   logic [CNT_W-1:0] count;

   assign expired = en && (count == LAST);

   // Window counter: restarts on clear or on expiry so it can never wrap
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clear || expired) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/key_click_decoder.sv
// Groups debounced press pulses into single/double/triple click events.
// A group ends either on the third press or when no press arrives within
// WINDOW cycles of the previous one; each group yields one registered
// one-cycle event strobe.
module key_click_decoder
   import key_pkg::*;
#(
   parameter int               CNT_W  = KEY_CNT_W,
   parameter logic [CNT_W-1:0] WINDOW = KEY_WINDOW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pulse,
   output logic       evt_valid,
   output logic [1:0] evt_clicks,
   output logic       single_click,
   output logic       double_click,
   output logic       triple_click,
   output logic       busy
);

   state_t     state;
   state_t     state_next;
   logic [1:0] count;
   logic [1:0] count_next;
   logic       emit;
   logic [1:0] emit_clicks;
   logic       timer_en;
   logic       timer_clear;
   logic       expired;

   // The timer only runs while collecting and no press arrives; a press
   // (or being idle) restarts it, so a press always beats a timeout
   assign timer_en    = (state == ST_WAIT) && !key_pulse;
   assign timer_clear = !timer_en;

   click_window_timer #(
      .CNT_W  (CNT_W),
      .WINDOW (WINDOW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .en      (timer_en),
      .expired (expired)
   );

   // Next-state logic: count presses, close the group on the third press
   // or on window expiry, and decide what event to emit at this edge
   always_comb begin
      state_next  = state;
      count_next  = count;
      emit        = 1'b0;
      emit_clicks = CLK_NONE;
      case (state)
         ST_IDLE: begin
            if (key_pulse) begin
               state_next = ST_WAIT;
               count_next = 2'd1;
            end
         end
         ST_WAIT: begin
            if (key_pulse && (count == 2'd2)) begin
               emit        = 1'b1;
               emit_clicks = CLK_TRIPLE;
               state_next  = ST_IDLE;
               count_next  = 2'd0;
            end else if (key_pulse) begin
               count_next = count + 2'd1;
            end else if (expired) begin
               emit        = 1'b1;
               emit_clicks = count;
               state_next  = ST_IDLE;
               count_next  = 2'd0;
            end
         end
         default: begin
            state_next = ST_IDLE;
            count_next = 2'd0;
         end
      endcase
   end

   // State register and registered event outputs; reset drops any group
   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         count        <= 2'd0;
         evt_valid    <= 1'b0;
         evt_clicks   <= CLK_NONE;
         single_click <= 1'b0;
         double_click <= 1'b0;
         triple_click <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_next;
         count        <= count_next;
         evt_valid    <= emit;
         evt_clicks   <= emit_clicks;
         single_click <= emit && (emit_clicks == CLK_SINGLE);
         double_click <= emit && (emit_clicks == CLK_DOUBLE);
         triple_click <= emit && (emit_clicks == CLK_TRIPLE);
         busy         <= (state_next == ST_WAIT);
      end
   end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed self-checking bench for key_click_decoder with WINDOW=10.
// Output vector layout: {evt_valid, evt_clicks[1:0], single, double, triple, busy}.
module tb_key_click_decoder;

   logic       clk;
   logic       rst;
   logic       key_pulse;
   logic       evt_valid;
   logic [1:0] evt_clicks;
   logic       single_click;
   logic       double_click;
   logic       triple_click;
   logic       busy;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] V_IDLE   = 7'b0_00_000_0;
   localparam logic [6:0] V_BUSY   = 7'b0_00_000_1;
   localparam logic [6:0] V_SINGLE = 7'b1_01_100_0;
   localparam logic [6:0] V_DOUBLE = 7'b1_10_010_0;
   localparam logic [6:0] V_TRIPLE = 7'b1_11_001_0;

   key_click_decoder #(
      .CNT_W  (24),
      .WINDOW (24'd10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_pulse    (key_pulse),
      .evt_valid    (evt_valid),
      .evt_clicks   (evt_clicks),
      .single_click (single_click),
      .double_click (double_click),
      .triple_click (triple_click),
      .busy         (busy)
   );

   // 100 MHz simulation clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive key_pulse for one rising edge, then sample 1 ns after that edge
   task automatic apply_stimulus(input logic kp);
      key_pulse = kp;
      @(posedge clk);
      #1;
      key_pulse = 1'b0;
   endtask

   // Compare the full output vector against the expected one
   task automatic check_output(input string tag, input logic [6:0] expected);
      logic [6:0] observed;
      observed = {evt_valid, evt_clicks, single_click, double_click, triple_click, busy};
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   // Step n idle edges, checking the same expected vector after each
   task automatic run_idle(input string tag, input int n, input logic [6:0] expected);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0);
         check_output($sformatf("%s_%0d", tag, i), expected);
      end
   endtask

   // Global guard so the run always ends
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      key_pulse = 1'b0;

      // Reset held for 3 edges while pressing: everything stays 0
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1);
         check_output($sformatf("reset_hold_%0d", i), V_IDLE);
      end
      rst = 1'b1;
      run_idle("after_reset", 12, V_IDLE);

      // Single: press at edge 0, event after edge 10
      apply_stimulus(1'b1);
      check_output("single_e0", V_BUSY);
      run_idle("single_wait", 9, V_BUSY);
      apply_stimulus(1'b0);
      check_output("single_evt", V_SINGLE);
      run_idle("single_after", 3, V_IDLE);

      // Double: presses at edges 0 and 6, event after edge 16
      apply_stimulus(1'b1);
      check_output("double_e0", V_BUSY);
      run_idle("double_wait_a", 5, V_BUSY);
      apply_stimulus(1'b1);
      check_output("double_e6", V_BUSY);
      run_idle("double_wait_b", 9, V_BUSY);
      apply_stimulus(1'b0);
      check_output("double_evt", V_DOUBLE);
      run_idle("double_after", 3, V_IDLE);

      // Triple: presses at edges 0, 3, 5; new group pressed at edge 6
      apply_stimulus(1'b1);
      check_output("triple_e0", V_BUSY);
      run_idle("triple_wait_a", 2, V_BUSY);
      apply_stimulus(1'b1);
      check_output("triple_e3", V_BUSY);
      run_idle("triple_wait_b", 1, V_BUSY);
      apply_stimulus(1'b1);
      check_output("triple_evt", V_TRIPLE);
      apply_stimulus(1'b1);
      check_output("b2b_e6", V_BUSY);
      run_idle("b2b_wait", 9, V_BUSY);
      apply_stimulus(1'b0);
      check_output("b2b_single_evt", V_SINGLE);
      run_idle("b2b_after", 12, V_IDLE);

      // Boundary: second press on the would-be timeout edge wins
      apply_stimulus(1'b1);
      check_output("bound_e0", V_BUSY);
      run_idle("bound_wait_a", 9, V_BUSY);
      apply_stimulus(1'b1);
      check_output("bound_e10", V_BUSY);
      run_idle("bound_wait_b", 9, V_BUSY);
      apply_stimulus(1'b0);
      check_output("bound_double_evt", V_DOUBLE);
      run_idle("bound_after", 3, V_IDLE);

      // Reset mid-group: presses at 0 and 2, reset at edge 4, no event
      apply_stimulus(1'b1);
      check_output("midrst_e0", V_BUSY);
      apply_stimulus(1'b0);
      check_output("midrst_e1", V_BUSY);
      apply_stimulus(1'b1);
      check_output("midrst_e2", V_BUSY);
      apply_stimulus(1'b0);
      check_output("midrst_e3", V_BUSY);
      rst = 1'b0;
      apply_stimulus(1'b0);
      check_output("midrst_e4", V_IDLE);
      rst = 1'b1;
      run_idle("midrst_after", 20, V_IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_click_decoder.md
Name: key_click_decoder

Overview:
- Sits directly downstream of the key debounce/filter stage and consumes its one-cycle press pulse.
- Groups press pulses that arrive within a time window into single, double or triple click events.
- Emits one registered one-cycle event pulse per group, for the mode/control logic of the board design (50 MHz clk).

Parameters:
- WINDOW, 24'd15_000_000, inter-click window in clk cycles (300 ms at 50 MHz); legal range 2 to 2^CNT_W-1; sims use 10.
- CNT_W, 24, width of the window timer; must hold WINDOW-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- key_pulse  input  1  one-cycle press pulse from the debounce stage, already synchronous to clk.
- evt_valid  output  1  one-cycle strobe: a click group has completed.
- evt_clicks  output  2  number of clicks in the group (1..3); valid only while evt_valid=1, otherwise 0.
- single_click  output  1  one-cycle strobe, equals evt_valid and evt_clicks==1.
- double_click  output  1  one-cycle strobe, equals evt_valid and evt_clicks==2.
- triple_click  output  1  one-cycle strobe, equals evt_valid and evt_clicks==3.
- busy  output  1  high while a click group is being collected (state WAIT).

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE; timer=0; click count=0.
  - All outputs are 0 (evt_valid, evt_clicks, single_click, double_click, triple_click, busy).
  - Reset mid-group discards the group and emits no event.
- All outputs are registered. Every event strobe is high for exactly one cycle.
- IDLE state:
  - key_pulse=1 -> state WAIT, count=1, timer=0, busy=1 from the next cycle.
  - key_pulse=0 -> remain in IDLE.
- WAIT state, evaluated in priority order each edge:
  1. key_pulse=1 and count==2 -> emit event with clicks=3 at this edge; state IDLE; count=0; timer=0.
  2. key_pulse=1 and count<2 -> count+1; timer=0; stay in WAIT.
  3. timer==WINDOW-1 -> emit event with clicks=count; state IDLE; count=0; timer=0.
  4. Otherwise -> timer+1.
- Simultaneous key_pulse and timeout: the press wins. It is counted and the timer restarts, or the third click is emitted immediately.
- Latency:
  - Timeout event: evt_valid is high in the cycle after the WINDOW-th rising edge following the edge that sampled the last press.
  - Triple event: evt_valid is high in the cycle after the edge that sampled the third press.
- key_pulse during the emit cycle (the state is already IDLE at that edge): it starts a new group on the next edge. No press is ever dropped except under reset.
- Timer: unsigned CNT_W bits. It never wraps, because it is cleared at WINDOW-1. The count is 2 bits and saturates by construction (max 3).
- key_pulse held high for several cycles is outside the contract. Each high cycle is counted as one press.

Decomposition:
- Shared package key_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_WAIT=1'b1;
  - click codes CLK_NONE=2'd0, CLK_SINGLE=2'd1, CLK_DOUBLE=2'd2, CLK_TRIPLE=2'd3;
  - the default WINDOW constant, shared with the debounce MAX constant style.
- One sub-module, click_window_timer. Inputs: clk, rst, clear, en. Output: expired, which equals 1 when the count is at WINDOW-1 and en=1. The parent instantiates it with WINDOW and CNT_W passed through.

Test Plan (WINDOW=10):
- Reset: hold rst=0 for 3 cycles while pulsing key_pulse -> all outputs 0, busy=0. After release, no event.
- Single: pulse at edge 0 -> busy=1 from cycle 1. evt_valid=1, evt_clicks=1, single_click=1 for exactly one cycle after edge 10. busy=0 afterwards.
- Double: pulses at edges 0 and 6 -> a single event with evt_clicks=2 and double_click=1, after edge 16. Nothing emitted at edge 10.
- Triple and back-to-back:
  - Pulses at edges 0, 3, 5 -> triple_click=1 after edge 5, no later timeout event.
  - Further pulse at edge 6 -> new group, single_click after edge 16.
- Boundary: pulses at edges 0 and 10 (the coincident timeout edge) -> press wins. No single event; double_click after edge 20.
- Reset mid-group: pulses at edges 0 and 2, rst=0 at edge 4 -> no event ever. busy=0 from cycle 5.
